decoder_grant_arbiter: RTL and testbench

//  Round-robin arbiter that shares one decoder_4to16 among 16 requesters.

---
 rtl/decoder_grant_arbiter_pkg.sv | 30 +++
 rtl/decoder_4to16.sv | 25 ++
 rtl/decoder_grant_arbiter.sv | 131 +++++++++++++
 tb/tb_decoder_grant_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared types and the round-robin search used by decoder_grant_arbiter.
// Package name is dec_arb_pkg; imported by the arbiter top.
package dec_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Returns {found, idx}: first set request at ptr, ptr+1, ... wrapping mod 16.
    // Walking from the far end lets the nearest hit overwrite the others.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_4to16.sv
// Plain 4-to-16 line decoder with enable; A is the MSB of the select.
// Output is all-zero while en_i is low.
module decoder_4to16 (
    input  logic        a_i,
    input  logic        b_i,
    input  logic        c_i,
    input  logic        d_i,
    input  logic        en_i,
    output logic [15:0] y_o
);

    logic [3:0] sel;

    assign sel = {a_i, b_i, c_i, d_i};

    always_comb begin
        y_o = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (en_i && (sel == 4'(i))) begin
                y_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter sharing one decoder_4to16 among 16 requesters, with a
// one-cycle dead gap between owners. Define ARB_TIMEOUT_EN to add forced revoke.
module decoder_grant_arbiter
    import dec_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               timeout
);

    // Handshake: req[i] is a level held until the requester is done; gnt[i]
    // high means i owns the decoder. Dropping req[i] while granted ends the
    // ownership; gnt then reads zero for one GAP cycle before the next owner.

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_grant_arbiter: MAX_HOLD must be in 2..255");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             gnt_en_q, gnt_en_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W:0]   pick;
    logic             hold_expired;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    // Counter reads 0 on the first GRANT cycle because it is cleared outside GRANT.
    assign hold_cnt_d   = (state_q == ST_GRANT) ? hold_cnt_q + 8'd1 : 8'd0;
    assign hold_expired = (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign pick = rr_pick(req, ptr_q);

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && pick[IDX_W]) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = pick[IDX_W-1:0];
                end
            end
            ST_GRANT: begin
                if (!req[gnt_idx_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = gnt_idx_q + 4'd1;
                end else if (hold_expired) begin
                    state_d   = ST_GAP;
                    ptr_d     = gnt_idx_q + 4'd1;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                // ptr_q was already advanced past the previous owner on entry.
                if (arb_en && pick[IDX_W]) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = pick[IDX_W-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gnt_en_d = (state_d == ST_GRANT);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            gnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            gnt_en_q  <= gnt_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    decoder_4to16 u_dec (
        .a_i  (gnt_idx_q[3]),
        .b_i  (gnt_idx_q[2]),
        .c_i  (gnt_idx_q[1]),
        .d_i  (gnt_idx_q[0]),
        .en_i (gnt_en_q),
        .y_o  (gnt)
    );

    assign gnt_idx = gnt_idx_q;
    assign gnt_en  = gnt_en_q;
    assign busy    = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Bench for decoder_grant_arbiter: directed scenarios plus random traffic,
// checked every cycle against an ownership model. Honours ARB_TIMEOUT_EN.
module tb_decoder_grant_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic        arb_en;
  logic [15:0] req;
  logic [3:0]  gnt_idx;
  logic        gnt_en;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  decoder_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ownership model: who owns the decoder, for how many cycles, and whether
  // we are in the dead cycle that follows an owner
  bit m_owned;
  bit m_gap;
  bit m_to;
  int m_idx;
  int m_ptr;
  int m_cycles;

  function automatic int rr_first(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owned = 0; m_gap = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_cycles = 0;
    end else begin
      m_to = 0;
      if (m_owned) begin
        if (!req[m_idx]) begin
          m_owned = 0; m_gap = 1; m_ptr = (m_idx + 1) % 16;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cycles == MAX_HOLD) begin
          m_owned = 0; m_gap = 1; m_to = 1; m_ptr = (m_idx + 1) % 16;
        end
`endif
        else begin
          m_cycles++;
        end
      end else begin
        int w;
        m_gap = 0;
        w = rr_first(req, m_ptr);
        if (arb_en && w >= 0) begin
          m_owned = 1; m_idx = w; m_cycles = 1;
        end
      end
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [15:0] e_gnt;
    e_gnt = m_owned ? (16'h0001 << m_idx) : 16'h0000;
    chk("cyc_gnt",     32'(gnt),     32'(e_gnt));
    chk("cyc_gnt_en",  32'(gnt_en),  32'(m_owned));
    chk("cyc_busy",    32'(busy),    32'(m_owned | m_gap));
    chk("cyc_gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("cyc_timeout", 32'(timeout), 32'(m_to));
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n = 1'b1; arb_en = 1'b1; req = 16'h0000;

    // 1: reset with every request high
    #1 rst_n = 1'b0; req = 16'hFFFF;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_en", 32'(gnt_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_first_owner", 32'(gnt), 32'h0001);
    req = 16'h0000;
    cycles(3);

    // 2: single requester 5
    req = 16'h0020;
    cycles(1);
    chk("t2_idx", 32'(gnt_idx), 32'd5);
    chk("t2_gnt", 32'(gnt), 32'h0020);
    req = 16'h0000;
    cycles(1);
    chk("t2_gap_gnt", 32'(gnt), 32'h0);
    chk("t2_gap_busy", 32'(busy), 32'h1);
    cycles(1);
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // 3: wrap-around order 15 -> 0 -> 3 after owner 3
    req = 16'h0008;
    cycles(1);
    chk("t3_own3", 32'(gnt), 32'h0008);
    req = 16'h8001;
    cycles(1);
    chk("t3_gap1", 32'(gnt), 32'h0);
    cycles(1);
    chk("t3_own15", 32'(gnt), 32'h8000);
    req = 16'h0009;
    cycles(1);
    chk("t3_gap2", 32'(gnt), 32'h0);
    cycles(1);
    chk("t3_own0", 32'(gnt), 32'h0001);
    req = 16'h0008;
    cycles(1);
    chk("t3_gap3", 32'(gnt), 32'h0);
    cycles(1);
    chk("t3_own3b", 32'(gnt), 32'h0008);
    req = 16'h0000;
    cycles(3);

    // 4: arb_en low blocks new grants
    arb_en = 1'b0; req = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("t4_blocked", 32'(gnt), 32'h0);
    end
    arb_en = 1'b1;
    cycles(1);
    chk("t4_released", 32'(gnt), 32'h0100);
    arb_en = 1'b0;
    cycles(2);
    chk("t4_hold_arb_off", 32'(gnt), 32'h0100);
    req = 16'h0000; arb_en = 1'b1;
    cycles(3);

    // 5: two long requesters (forced revoke when timeout is built in)
    reset_pulse();
    req = 16'h0204;
    cycles(1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("t5_own2", 32'(gnt), 32'h0004);
      if (i < MAX_HOLD - 1) cycles(1);
    end
    cycles(1);
    chk("t5_timeout", 32'(timeout), 32'h1);
    chk("t5_gap", 32'(gnt), 32'h0);
    cycles(1);
    chk("t5_own9", 32'(gnt), 32'h0200);
    chk("t5_to_clear", 32'(timeout), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("t5_hold2", 32'(gnt), 32'h0004);
      cycles(1);
    end
`endif
    req = 16'h0000;
    cycles(3);

    // 6: async reset in the middle of owner 7's grant
    req = 16'h0080;
    cycles(2);
    chk("t6_own7", 32'(gnt), 32'h0080);
    req = 16'h0081;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'h0);
    chk("t6_async_en", 32'(gnt_en), 32'h0);
    #1 rst_n = 1'b1;
    cycles(2);
    chk("t6_own0", 32'(gnt), 32'h0001);
    req = 16'h0000;
    cycles(3);

    // random traffic with occasional async resets
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end else if (r < 45) begin
        req = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535))
              & 16'($urandom_range(0, 65535));
      end else if (r < 50) begin
        req = 16'h0000;
      end
      arb_en = ($urandom_range(0, 9) != 0);
    end

    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
